mult_unit: RTL

//   Iterative shift-add multiplier in the execute stage, directly downstream of RegisterFile.

---
 rtl/mult_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for LEGv8 MUL / UMULH / SMULH with a RegisterFile write request.
// Optional feature macro: MULT_EARLY_EXIT_EN (finish as soon as the remaining multiplier bits are zero).
module mult_unit #(
  parameter int WIDTH          = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  input  logic [4:0]       RW_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       RW_out,
  output logic             RegWr,
  output logic [1:0]       Dbg_state
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2 * WIDTH;

  localparam logic [CW-1:0] N_C   = CW'(N);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  // Handshake: Start is a single-cycle request sampled only while Busy is low;
  // there is no backpressure or queueing, a Start seen while Busy is dropped.

  logic [1:0]       state_q,  state_d;
  logic [PW-1:0]    mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q,    acc_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [1:0]       op_q,     op_d;
  logic             neg_q,    neg_d;
  logic [4:0]       rw_q,     rw_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       rw_out_q, rw_out_d;
  logic             regwr_q,  regwr_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    prod_fin;
  logic [WIDTH-1:0] remaining;
  logic             last_grp;
  logic [WIDTH-1:0] sel_word;

  // SMULH works on magnitudes; the product sign is reapplied on entry to DONE.
  always_comb begin
    a_neg = (Op == OP_SMULH) & BusA[WIDTH-1];
    b_neg = (Op == OP_SMULH) & BusB[WIDTH-1];
    a_mag = a_neg ? -BusA : BusA;
    b_mag = b_neg ? -BusB : BusB;
  end

  // Carries above bit 2*WIDTH are discarded, so the accumulator wraps modulo 2^(2*WIDTH).
  always_comb begin
    addend = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier_q[j]) begin
        addend = addend + (mcand_q << j);
      end
    end
    acc_next = acc_q + addend;
    prod_fin = neg_q ? -acc_next : acc_next;
  end

  always_comb begin
    remaining = mplier_q >> BITS_PER_CYCLE;
`ifdef MULT_EARLY_EXIT_EN
    last_grp  = (cnt_q == ONE_C) || (remaining == '0);
`else
    last_grp  = (cnt_q == ONE_C);
`endif
  end

  always_comb begin
    case (op_q)
      OP_UMULH, OP_SMULH: sel_word = prod_fin[PW-1:WIDTH];
      default:            sel_word = prod_fin[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rw_d     = rw_q;
    result_d = result_q;
    rw_out_d = rw_out_q;
    regwr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d  = S_CALC;
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = N_C;
          op_d     = Op;
          neg_d    = a_neg ^ b_neg;
          rw_d     = RW_in;
        end
      end
      S_CALC: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = remaining;
        cnt_d    = cnt_q - ONE_C;
        if (last_grp) begin
          state_d  = S_DONE;
          result_d = sel_word;
          rw_out_d = rw_q;
          regwr_d  = (rw_q != 5'd31);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rw_q     <= '0;
      result_q <= '0;
      rw_out_q <= '0;
      regwr_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rw_q     <= rw_d;
      result_q <= result_d;
      rw_out_q <= rw_out_d;
      regwr_q  <= regwr_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Done      = (state_q == S_DONE);
  assign Result    = result_q;
  assign RW_out    = rw_out_q;
  assign RegWr     = regwr_q;
  assign Dbg_state = state_q;

endmodule
